// File: rtl/alu_share_pkg.sv
// Shared opcode constants, FSM state type and defaults for the ALU sharing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_share_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    localparam int DIV_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_share_state_t;

    // Div and mod are the slow combinational paths that need a multi-cycle hold.
    function automatic logic is_slow_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Purely combinational shared ALU: add/sub/mul wrap, unsigned div/mod, illegal ops give 0.
// Latency: combinational; div/mod paths are slow and must be held stable by the caller.
// Backpressure: none; output follows inputs.
module ALU
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y
);

    // Divide-by-zero is given a fixed, defined answer: all ones for div, the dividend for mod.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_DIV:  y = (b == '0) ? '1 : a / b;
            OP_MOD:  y = (b == '0) ? a : a % b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between two requesters; optional rsp_err via ALU_SHARE_ERR_EN.
// Latency: accept at T, rsp_valid at T+2 (add/sub/mul/illegal) or T+1+DIV_LAT (div/mod).
// Backpressure: result held until rsp_ready; no request accepted until the response is taken.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
`ifdef ALU_SHARE_ERR_EN
    ,
    output logic             rsp_err
`endif
);

    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    alu_share_state_t state, state_nxt;

    logic             last_grant;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] alu_y;

    logic             grant0, grant1;
    logic             accept, capture, rsp_done;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [3:0]       sel_op;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        sel_a  = grant1 ? req1_a  : req0_a;
        sel_b  = grant1 ? req1_b  : req0_b;
        sel_op = grant1 ? req1_op : req0_op;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake strobes; ready is gated by reset so it reads 0 while held in reset.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (grant0 || grant1)) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                    accept     = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, hold counter and registered response; operands only move on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            id_q       <= 1'b0;
            cnt        <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                a_q        <= sel_a;
                b_q        <= sel_b;
                op_q       <= sel_op;
                id_q       <= grant1;
                last_grant <= grant1;
                cnt        <= is_slow_op(sel_op) ? DIV_CNT : 4'd1;
            end else if (state == EXEC) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_y;
                rsp_id    <= id_q;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SHARE_ERR_EN
    logic err_calc;

    // Error covers divide/modulo by zero and any opcode past OP_MOD; data stays the ALU output.
    always_comb begin
        err_calc = (is_slow_op(op_q) && (b_q == '0)) || (op_q > OP_MOD);
    end

    // Error flag travels with the captured result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= err_calc;
        end
    end
`endif

    ALU #(.WIDTH(WIDTH)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: bench stalls rsp_ready to exercise result hold.
module tb_alu_share_ctrl;

    localparam int W  = 32;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_op = '0, req1_op = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [W-1:0]  rsp_data;
`ifdef ALU_SHARE_ERR_EN
    logic          rsp_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Recorded observations from serve().
    int           acc_id_q[$];
    int           acc_cyc_q[$];
    int           rsp_cyc_q[$];
    int           hs_cyc_q[$];
    logic         rid_q[$];
    logic [W-1:0] rdat_q[$];
    logic         rerr_q[$];
    int           unstable, rdy_busy, both_rdy, timeout;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_ctrl #(.WIDTH(W), .DIV_LAT(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef ALU_SHARE_ERR_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    // Reference: {err, data} from the arithmetic rules.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
            4'd2: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p[31:0]}; end
            4'd3: return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            4'd4: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? DL + 1 : 2;
    endfunction

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_rec();
        acc_id_q.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete(); hs_cyc_q.delete();
        rid_q.delete(); rdat_q.delete(); rerr_q.delete();
        unstable = 0; rdy_busy = 0; both_rdy = 0; timeout = 0;
    endtask

    // Drives up to two requests concurrently and records what the DUT does; no judging here.
    task automatic serve(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input int stall);
        logic p0, p1, busy, seen, herr;
        logic [31:0] hd;
        logic hid;
        int scnt, budget;
        p0 = v0; p1 = v1; busy = 1'b0; seen = 1'b0; scnt = 0; budget = 0;
        hd = '0; hid = 1'b0; herr = 1'b0;
        req0_op = op0; req0_a = a0; req0_b = b0; req0_valid = p0;
        req1_op = op1; req1_a = a1; req1_b = b1; req1_valid = p1;
        while ((p0 || p1 || busy) && budget < 300) begin
            @(negedge clk);
            budget++;
            if (req0_ready && req1_ready) both_rdy++;
            if ((req0_ready || req1_ready) && busy) rdy_busy++;
            if (req0_ready) begin
                acc_id_q.push_back(0); acc_cyc_q.push_back(cyc); p0 = 1'b0; busy = 1'b1;
            end else if (req1_ready) begin
                acc_id_q.push_back(1); acc_cyc_q.push_back(cyc); p1 = 1'b0; busy = 1'b1;
            end
            if (rsp_valid) begin
`ifdef ALU_SHARE_ERR_EN
                herr = rsp_err;
`endif
                if (!seen) begin
                    seen = 1'b1; rsp_cyc_q.push_back(cyc); hd = rsp_data; hid = rsp_id;
                end else if (rsp_data !== hd || rsp_id !== hid) begin
                    unstable++;
                end
                if (scnt >= stall) begin
                    rsp_ready = 1'b1;
                    rid_q.push_back(rsp_id); rdat_q.push_back(rsp_data); rerr_q.push_back(herr);
                    hs_cyc_q.push_back(cyc);
                    busy = 1'b0; seen = 1'b0; scnt = 0;
                end else begin
                    rsp_ready = 1'b0;
                    scnt++;
                end
            end else begin
                rsp_ready = 1'b0;
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            if (!p0 && req0_valid) begin req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; end
            if (!p1 && req1_valid) begin req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; end
        end
        if (budget >= 300) timeout++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
`ifdef ALU_SHARE_ERR_EN
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_add();
        clear_rec();
        serve(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        total++; if (timeout != 0 || rdat_q.size() != 1 || acc_id_q.size() != 1) begin
            bad++; $display("FAIL add_count got=%0d exp=1", rdat_q.size()); return;
        end
        total++; if (acc_id_q[0] != 0) begin bad++; $display("FAIL add_grant got=%0d exp=0", acc_id_q[0]); end
        total++; if (rsp_cyc_q[0] - acc_cyc_q[0] != 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", rsp_cyc_q[0] - acc_cyc_q[0]); end
        total++; if (rdat_q[0] !== 32'd12) begin bad++; $display("FAIL add_data got=%h exp=%h", rdat_q[0], 32'd12); end
        total++; if (rid_q[0] !== 1'b0) begin bad++; $display("FAIL add_id got=%b exp=0", rid_q[0]); end
    endtask

    task automatic test_tie();
        apply_reset();
        clear_rec();
        serve(1'b1, 4'd1, 32'd10, 32'd3, 1'b1, 4'd2, 32'd6, 32'd7, 0);
        serve(1'b1, 4'd1, 32'd10, 32'd3, 1'b1, 4'd2, 32'd6, 32'd7, 0);
        total++; if (timeout != 0 || rdat_q.size() != 4 || acc_id_q.size() != 4) begin
            bad++; $display("FAIL tie_count got=%0d exp=4", rdat_q.size()); return;
        end
        total++; if (acc_id_q[0] != 0 || acc_id_q[1] != 1) begin bad++; $display("FAIL tie_order got=%0d,%0d exp=0,1", acc_id_q[0], acc_id_q[1]); end
        total++; if (rdat_q[0] !== 32'd7 || rid_q[0] !== 1'b0) begin bad++; $display("FAIL tie_first got=%h/%b exp=7/0", rdat_q[0], rid_q[0]); end
        total++; if (rdat_q[1] !== 32'd42 || rid_q[1] !== 1'b1) begin bad++; $display("FAIL tie_second got=%h/%b exp=2a/1", rdat_q[1], rid_q[1]); end
        total++; if (acc_cyc_q[1] - acc_cyc_q[0] != 3) begin bad++; $display("FAIL tie_spacing got=%0d exp=3", acc_cyc_q[1] - acc_cyc_q[0]); end
        total++; if (acc_id_q[2] != 0 || acc_id_q[3] != 1) begin bad++; $display("FAIL tie_repeat got=%0d,%0d exp=0,1", acc_id_q[2], acc_id_q[3]); end
        total++; if (both_rdy != 0 || rdy_busy != 0) begin bad++; $display("FAIL tie_ready_excl got=%0d/%0d exp=0/0", both_rdy, rdy_busy); end
    endtask

    task automatic test_div();
        clear_rec();
        serve(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd3, 32'd100, 32'd7, 0);
        serve(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd4, 32'd100, 32'd7, 0);
        total++; if (timeout != 0 || rdat_q.size() != 2) begin bad++; $display("FAIL div_count got=%0d exp=2", rdat_q.size()); return; end
        total++; if (rsp_cyc_q[0] - acc_cyc_q[0] != DL + 1) begin bad++; $display("FAIL div_latency got=%0d exp=%0d", rsp_cyc_q[0] - acc_cyc_q[0], DL + 1); end
        total++; if (rdat_q[0] !== 32'd14 || rid_q[0] !== 1'b1) begin bad++; $display("FAIL div_data got=%h/%b exp=e/1", rdat_q[0], rid_q[0]); end
        total++; if (rdat_q[1] !== 32'd2) begin bad++; $display("FAIL mod_data got=%h exp=2", rdat_q[1]); end
        total++; if (rsp_cyc_q[1] - acc_cyc_q[1] != DL + 1) begin bad++; $display("FAIL mod_latency got=%0d exp=%0d", rsp_cyc_q[1] - acc_cyc_q[1], DL + 1); end
    endtask

    task automatic test_wrap();
        clear_rec();
        serve(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        serve(1'b1, 4'd1, 32'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        total++; if (timeout != 0 || rdat_q.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", rdat_q.size()); return; end
        total++; if (rdat_q[0] !== 32'd0) begin bad++; $display("FAIL wrap_add got=%h exp=0", rdat_q[0]); end
        total++; if (rdat_q[1] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_sub got=%h exp=ffffffff", rdat_q[1]); end
    endtask

    task automatic test_backpressure();
        logic [32:0] e;
        clear_rec();
        serve(1'b1, 4'd2, 32'd1234, 32'd5678, 1'b1, 4'd0, 32'd9, 32'd1, 6);
        total++; if (timeout != 0 || rdat_q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", rdat_q.size()); return; end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        total++; if (rdy_busy != 0) begin bad++; $display("FAIL bp_ready_low got=%0d exp=0", rdy_busy); end
        total++; if (hs_cyc_q[0] - rsp_cyc_q[0] != 6) begin bad++; $display("FAIL bp_hold got=%0d exp=6", hs_cyc_q[0] - rsp_cyc_q[0]); end
        total++; if (acc_cyc_q[1] - hs_cyc_q[0] != 1) begin bad++; $display("FAIL bp_idle_next got=%0d exp=1", acc_cyc_q[1] - hs_cyc_q[0]); end
        for (int k = 0; k < 2; k++) begin
            e = (rid_q[k] == 1'b0) ? ref_alu(4'd2, 32'd1234, 32'd5678) : ref_alu(4'd0, 32'd9, 32'd1);
            total++; if (rdat_q[k] !== e[31:0]) begin bad++; $display("FAIL bp_data%0d got=%h exp=%h", k, rdat_q[k], e[31:0]); end
        end
    endtask

`ifdef ALU_SHARE_ERR_EN
    task automatic test_err();
        clear_rec();
        serve(1'b1, 4'd3, 32'd9, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        serve(1'b1, 4'd7, 32'd9, 32'd3, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        serve(1'b1, 4'd4, 32'd5, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        serve(1'b1, 4'd0, 32'd5, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        total++; if (timeout != 0 || rdat_q.size() != 4) begin bad++; $display("FAIL err_count got=%0d exp=4", rdat_q.size()); return; end
        total++; if (rerr_q[0] !== 1'b1 || rdat_q[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL err_div0 got=%b/%h exp=1/ffffffff", rerr_q[0], rdat_q[0]); end
        total++; if (rsp_cyc_q[0] - acc_cyc_q[0] != DL + 1) begin bad++; $display("FAIL err_div0_lat got=%0d exp=%0d", rsp_cyc_q[0] - acc_cyc_q[0], DL + 1); end
        total++; if (rerr_q[1] !== 1'b1 || rdat_q[1] !== 32'd0) begin bad++; $display("FAIL err_illegal got=%b/%h exp=1/0", rerr_q[1], rdat_q[1]); end
        total++; if (rerr_q[2] !== 1'b1 || rdat_q[2] !== 32'd5) begin bad++; $display("FAIL err_mod0 got=%b/%h exp=1/5", rerr_q[2], rdat_q[2]); end
        total++; if (rerr_q[3] !== 1'b0 || rdat_q[3] !== 32'd5) begin bad++; $display("FAIL err_clean got=%b/%h exp=0/5", rerr_q[3], rdat_q[3]); end
    endtask
`endif

    task automatic test_reset_mid();
        logic got;
        int vseen;
        apply_reset();
        req1_op = 4'd3; req1_a = 32'd100; req1_b = 32'd7; req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req1_ready) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL rmid_accept got=0 exp=1"); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_op = 4'd0; req0_a = 32'd2; req0_b = 32'd3; req0_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        vseen = 0;
        @(negedge clk);
        if (rsp_valid) vseen++;
        @(negedge clk);
        if (rsp_valid) vseen++;
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0) begin
            bad++; $display("FAIL rmid_outputs got=%b/%h/%b exp=0/0/0", rsp_valid, rsp_data, rsp_id);
        end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b%b exp=00", req0_ready, req1_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_rec();
        serve(1'b1, 4'd0, 32'd2, 32'd3, 1'b0, 4'd0, 32'd0, 32'd0, 0);
        repeat (DL + 2) begin
            @(negedge clk);
            if (rsp_valid) vseen++;
        end
        total++; if (vseen != 0) begin bad++; $display("FAIL rmid_stale_rsp got=%0d exp=0", vseen); end
        total++; if (timeout != 0 || rdat_q.size() != 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", rdat_q.size()); return; end
        total++; if (rdat_q[0] !== 32'd5 || rid_q[0] !== 1'b0) begin bad++; $display("FAIL rmid_data got=%h/%b exp=5/0", rdat_q[0], rid_q[0]); end
        total++; if (rsp_cyc_q[0] - acc_cyc_q[0] != 2) begin bad++; $display("FAIL rmid_latency got=%0d exp=2", rsp_cyc_q[0] - acc_cyc_q[0]); end
    endtask

    task automatic test_random();
        logic        lg;
        logic        v0, v1;
        logic [3:0]  op[2];
        logic [31:0] a[2], b[2];
        int          order[$];
        int          n, st;
        logic [32:0] e;
        apply_reset();
        lg = 1'b1;
        for (int it = 0; it < 40; it++) begin
            v0 = $urandom_range(0, 1); v1 = $urandom_range(0, 1);
            if (!v0 && !v1) v0 = 1'b1;
            for (int r = 0; r < 2; r++) begin
                op[r] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                a[r]  = $urandom;
                b[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
`ifndef ALU_SHARE_ERR_EN
                if ((op[r] == 4'd3 || op[r] == 4'd4) && b[r] == 0) b[r] = 32'd1;
`endif
            end
            order.delete();
            if (v0 && v1) begin
                if (lg) begin order.push_back(0); order.push_back(1); end
                else    begin order.push_back(1); order.push_back(0); end
            end else begin
                order.push_back(v1 ? 1 : 0);
            end
            lg = order[order.size() - 1][0];
            st = $urandom_range(0, 3);
            clear_rec();
            serve(v0, op[0], a[0], b[0], v1, op[1], a[1], b[1], st);
            n = order.size();
            total++; if (timeout != 0 || rdat_q.size() != n || acc_id_q.size() != n) begin
                bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, rdat_q.size(), n); return;
            end
            total++; if (rdy_busy != 0 || both_rdy != 0 || unstable != 0) begin
                bad++; $display("FAIL rnd%0d_protocol got=%0d/%0d/%0d exp=0/0/0", it, rdy_busy, both_rdy, unstable);
            end
            for (int k = 0; k < n; k++) begin
                e = ref_alu(op[order[k]], a[order[k]], b[order[k]]);
                total++; if (acc_id_q[k] != order[k] || rid_q[k] !== order[k][0]) begin
                    bad++; $display("FAIL rnd%0d_id%0d got=%0d/%b exp=%0d", it, k, acc_id_q[k], rid_q[k], order[k]);
                end
                total++; if (rdat_q[k] !== e[31:0]) begin
                    bad++; $display("FAIL rnd%0d_data%0d op=%0d got=%h exp=%h", it, k, op[order[k]], rdat_q[k], e[31:0]);
                end
                total++; if (rsp_cyc_q[k] - acc_cyc_q[k] != ref_lat(op[order[k]])) begin
                    bad++; $display("FAIL rnd%0d_lat%0d got=%0d exp=%0d", it, k, rsp_cyc_q[k] - acc_cyc_q[k], ref_lat(op[order[k]]));
                end
`ifdef ALU_SHARE_ERR_EN
                total++; if (rerr_q[k] !== e[32]) begin
                    bad++; $display("FAIL rnd%0d_err%0d got=%b exp=%b", it, k, rerr_q[k], e[32]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_tie();
        test_div();
        test_wrap();
        test_backpressure();
`ifdef ALU_SHARE_ERR_EN
        test_err();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and arbitration controller that shares the single 32-bit `ALU` datapath between two requesters, such as the core pipeline and an auxiliary unit. It accepts operations through valid/ready handshakes and arbitrates round-robin. It holds the ALU operands stable for one cycle (add/sub/mul) or `DIV_LAT` cycles (div/mod, which are slow combinational paths). It returns a registered, tagged result through a response handshake with backpressure.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `DIV_LAT`, 4, EXEC cycles for op 3/4 (legal range 1–15)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active-low
- `req0_valid`, `req1_valid`  in  1  requester has an operation pending
- `req0_ready`, `req1_ready`  out  1  operation accepted this cycle
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_op`, `req1_op`  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5–15 illegal
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_id`  out  1  requester index of result
- `rsp_data`  out  WIDTH  result
- `rsp_err`  out  1  error flag; exists only with `ALU_SHARE_ERR_EN`

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all ready outputs 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_err` 0. `last_grant` resets to 1, so requester 0 wins the first tie.
- IDLE:
  - If any `reqN_valid` is high, grant one requester. With both high, grant the one that is not `last_grant`.
  - `reqN_ready` is combinational: high only in IDLE, and only for the granted requester.
  - On accept: latch a, b, op and id; update `last_grant`; load the cycle counter (`DIV_LAT` for op 3/4, else 1); go to EXEC.
- EXEC:
  - The `ALU` instance is driven only from the latched registers.
  - The counter decrements each cycle.
  - When the counter reaches 1, capture the ALU output into `rsp_data`, set `rsp_valid`, and go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id`, `rsp_data` and `rsp_err` stable until `rsp_ready`.
  - On the handshake, clear `rsp_valid` and go to IDLE.
  - No new request is accepted in the handshake cycle.
- Requesters must hold valid and operands stable until ready. Operands are not sampled after accept.
- Arithmetic:
  - Results are WIDTH bits; add, sub and mul wrap modulo 2^WIDTH.
  - Div and mod are unsigned.
  - Illegal ops yield 0.
- A reset mid-operation discards any in-flight result; no response is issued.

## Timing
- Accept in cycle T. For ops 0–2, `rsp_valid` is high at T+2. For op 3/4, `rsp_valid` is high at T+1+`DIV_LAT`.
- Minimum request-to-request spacing is 3 cycles: IDLE, EXEC, RESP with `rsp_ready` held high.
- Only one operation is in flight; there is no pipelining.
- The ALU operand inputs change only on the IDLE→EXEC transition.

## Configuration
- Macro: `ALU_SHARE_ERR_EN`.
- Defined:
  - `rsp_err` port exists.
  - Div or mod with b=0 sets `rsp_err`=1. For those cases `rsp_data` is 0xFFFFFFFF (div) or the a operand (mod).
  - An illegal op sets `rsp_err`=1 with `rsp_data`=0.
  - Div by zero still takes `DIV_LAT` cycles.
- Undefined:
  - No `rsp_err` port.
  - `rsp_data` is the raw ALU output in every case, including b=0.

## Structure
- Package `alu_share_pkg`:
  - opcode constants `OP_ADD`=4'b0000, `OP_SUB`, `OP_MUL`, `OP_DIV`, `OP_MOD`
  - state enum `alu_share_state_t` (IDLE, EXEC, RESP)
  - `DIV_LAT_DEFAULT`=4
- One sub-module: the existing `ALU`, instantiated once. The arbiter and FSM live in the top module.

## Test plan
- req0 add a=5 b=7 with `rsp_ready`=1 → `req0_ready` high at T; `rsp_valid` at T+2 with `rsp_data`=12 and `rsp_id`=0.
- Both requesters valid from reset: req0 sub 10−3 and req1 mul 6×7 → req0 is granted first (`rsp_data`=7). req1 is granted next (`rsp_data`=42, id 1). Repeat the tie → req0 wins again.
- req1 div 100/7, `DIV_LAT`=4 → `rsp_valid` at T+5 with `rsp_data`=14. Then mod 100%7 → 2.
- Add 0xFFFFFFFF+1 → `rsp_data`=0, confirming wrap. Sub 0−1 → 0xFFFFFFFF.
- `rsp_ready` held low 6 cycles → `rsp_valid`, `rsp_data` and `rsp_id` stay stable; both ready outputs stay 0 while req0 is valid. Release `rsp_ready` → IDLE the next cycle.
- With `ALU_SHARE_ERR_EN`: div 9/0 → `rsp_err`=1, `rsp_data`=0xFFFFFFFF. Op 7 → `rsp_err`=1, `rsp_data`=0.
- `rst_n` low during EXEC of a div → no `rsp_valid`; all outputs at reset values next cycle; a new request is accepted cleanly after `rst_n` rises.
